run_feeder_8: RTL and testbench

Producer for one input port of the 8-wide merger. It takes a stream of single sorted tuples, packs them eight at a time into one wide word, and closes every run with an all-zero terminator word. Words are buffered in a first-word-fall-through FIFO whose data/empty/read signals connect directly to the merger's `i_fifo_N` / `i_fifo_N_empty` / `o_fifo_N_read`. One instance feeds each merger input.

---
 rtl/run_feeder_8.sv | 213 +++++++++++++++++++++
 tb/tb_run_feeder_8.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/run_feeder_8.sv
// Packs sorted single tuples eight per word into a FWFT buffer for one merger input,
// padding each run's final partial word and closing the run with an all-zero word.
module run_feeder_8 #(
   parameter int unsigned           DATA_WIDTH = 128,
   parameter int unsigned           KEY_WIDTH  = 80,
   parameter int unsigned           DEPTH      = 16,
   parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '1
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [DATA_WIDTH-1:0]   i_tuple,
   input  logic                    i_tuple_valid,
   input  logic                    i_tuple_last,
   output logic                    o_tuple_ready,
   output logic [8*DATA_WIDTH-1:0] o_data,
   output logic                    o_empty,
   input  logic                    i_read,
   output logic [15:0]             o_run_count,
   output logic                    o_err_zero,
   output logic                    o_err_order
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned WORD_W = 8 * DATA_WIDTH;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      FILL,
      PAD,
      TERM
   } state_t;

   state_t                  state;
   state_t                  state_nx;

   logic [2:0]              lane;
   logic [DATA_WIDTH-1:0]   lane_q [7];
   logic [WORD_W-1:0]       wdata;

   logic [WORD_W-1:0]       mem [DEPTH];
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [CNT_W-1:0]        count;

   logic [KEY_WIDTH-1:0]    key;
   logic [KEY_WIDTH-1:0]    prev_key;

   logic                    not_full;
   logic                    ready;
   logic                    accept;
   logic                    push;
   logic                    term_push;
   logic                    pop;

   assign not_full = (count < CNT_FULL);
   assign accept   = ready & i_tuple_valid;
   assign pop      = i_read & (count != '0);
   assign key      = i_tuple[KEY_WIDTH-1:0];

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= FILL;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         FILL: begin
            if (accept && i_tuple_last) begin
               state_nx = (lane == 3'd7) ? TERM : PAD;
            end
         end
         PAD: begin
            if (not_full) begin
               state_nx = TERM;
            end
         end
         TERM: begin
            if (not_full) begin
               state_nx = FILL;
            end
         end
         default: state_nx = FILL;
      endcase
   end

   always_comb begin
      ready     = 1'b0;
      push      = 1'b0;
      term_push = 1'b0;
      case (state)
         FILL: begin
            ready = not_full & ~i_rst;
            push  = not_full & ~i_rst & i_tuple_valid & (lane == 3'd7);
         end
         PAD: begin
            push = not_full;
         end
         TERM: begin
            push      = not_full;
            term_push = not_full;
         end
         default: begin
            ready     = 1'b0;
            push      = 1'b0;
            term_push = 1'b0;
         end
      endcase
   end

   assign o_tuple_ready = ready;

   // ---------------------------------------------------------------- packing
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         lane <= '0;
      end else if (accept) begin
         lane <= lane + 3'd1;
      end else if (state == PAD && push) begin
         lane <= '0;
      end
   end

   always_ff @(posedge i_clk) begin
      for (int unsigned k = 0; k < 7; k++) begin
         if (accept && lane == 3'(k)) begin
            lane_q[k] <= i_tuple;
         end
      end
   end

   // In PAD, lane holds the number of stored tuples, so lanes at or above it are padding.
   always_comb begin
      wdata = '0;
      case (state)
         FILL: begin
            for (int unsigned k = 0; k < 7; k++) begin
               wdata[k*DATA_WIDTH +: DATA_WIDTH] = lane_q[k];
            end
            wdata[7*DATA_WIDTH +: DATA_WIDTH] = i_tuple;
         end
         PAD: begin
            for (int unsigned k = 0; k < 7; k++) begin
               wdata[k*DATA_WIDTH +: DATA_WIDTH] = (lane > 3'(k)) ? lane_q[k] : PAD_VALUE;
            end
            wdata[7*DATA_WIDTH +: DATA_WIDTH] = PAD_VALUE;
         end
         default: wdata = '0;
      endcase
   end

   // ---------------------------------------------------------------- buffer
   always_ff @(posedge i_clk) begin
      if (push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign o_data  = mem[rd_ptr];
   assign o_empty = (count == '0);

   // ---------------------------------------------------------------- status
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         prev_key    <= '0;
         o_run_count <= '0;
         o_err_zero  <= 1'b0;
         o_err_order <= 1'b0;
      end else begin
         // Clearing to zero at each run start means the first key can never compare lower.
         if (accept) begin
            prev_key <= key;
         end else if (term_push) begin
            prev_key <= '0;
         end
         if (term_push) begin
            o_run_count <= o_run_count + 16'd1;
         end
         if (accept && i_tuple == '0) begin
            o_err_zero <= 1'b1;
         end
         if (accept && key < prev_key) begin
            o_err_order <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_run_feeder_8.sv
// Directed bench for run_feeder_8: packing, padding, terminators, backpressure,
// simultaneous push/pop with pointer wrap, error flags and mid-run reset.
module tb_run_feeder_8;

   localparam int unsigned DW = 32;

   logic            clk = 1'b0;
   logic            i_rst = 1'b1;
   logic [DW-1:0]   i_tuple = '0;
   logic            i_tuple_valid = 1'b0;
   logic            i_tuple_last = 1'b0;
   logic            o_tuple_ready;
   logic [8*DW-1:0] o_data;
   logic            o_empty;
   logic            i_read = 1'b0;
   logic [15:0]     o_run_count;
   logic            o_err_zero;
   logic            o_err_order;

   int checks = 0;
   int errors = 0;

   run_feeder_8 #(
      .DATA_WIDTH (DW),
      .KEY_WIDTH  (24),
      .DEPTH      (16)
   ) dut (
      .i_clk         (clk),
      .i_rst         (i_rst),
      .i_tuple       (i_tuple),
      .i_tuple_valid (i_tuple_valid),
      .i_tuple_last  (i_tuple_last),
      .o_tuple_ready (o_tuple_ready),
      .o_data        (o_data),
      .o_empty       (o_empty),
      .i_read        (i_read),
      .o_run_count   (o_run_count),
      .o_err_zero    (o_err_zero),
      .o_err_order   (o_err_order)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [8*DW-1:0] obs, input logic [8*DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Word of n consecutive keys starting at base, remaining lanes padded with all-ones.
   function automatic logic [8*DW-1:0] seq(input int unsigned base, input int unsigned n);
      logic [8*DW-1:0] w;
      for (int unsigned k = 0; k < 8; k++) begin
         w[k*DW +: DW] = (k < n) ? DW'(base + k) : '1;
      end
      return w;
   endfunction

   task automatic send(input int unsigned key, input logic last);
      int n;
      n = 0;
      i_tuple       = DW'(key);
      i_tuple_valid = 1'b1;
      i_tuple_last  = last;
      while (!o_tuple_ready && n < 100) begin
         step();
         n++;
      end
      chk("send_wait", (n < 100), 1'b1);
      step();
      i_tuple_valid = 1'b0;
      i_tuple_last  = 1'b0;
   endtask

   task automatic pop_word(input string tag, input logic [8*DW-1:0] exp);
      chk({tag, "_nonempty"}, o_empty, 1'b0);
      chk(tag, o_data, exp);
      i_read = 1'b1;
      step();
      i_read = 1'b0;
   endtask

   initial begin
      logic [8*DW-1:0] w;
      logic            r;
      int              acc;

      // Reset
      step();
      chk("ready_in_reset", o_tuple_ready, 1'b0);
      chk("reset_empty", o_empty, 1'b1);
      chk("reset_run_count", o_run_count, 16'd0);
      chk("reset_err_zero", o_err_zero, 1'b0);
      chk("reset_err_order", o_err_order, 1'b0);
      i_rst = 1'b0;
      #1;
      chk("ready_after_reset", o_tuple_ready, 1'b1);

      // Full words: keys 1..16
      for (int unsigned k = 1; k <= 16; k++) begin
         send(k, (k == 16));
         if (k == 8) begin
            chk("latency_empty", o_empty, 1'b0);
            chk("latency_data", o_data, seq(1, 8));
         end
      end
      chk("ready_low_term", o_tuple_ready, 1'b0);
      step();
      chk("run_count_1", o_run_count, 16'd1);
      chk("ready_after_term", o_tuple_ready, 1'b1);
      pop_word("full_w0", seq(1, 8));
      pop_word("full_w1", seq(9, 8));
      pop_word("full_term", '0);
      chk("full_empty", o_empty, 1'b1);
      chk("full_err_zero", o_err_zero, 1'b0);
      chk("full_err_order", o_err_order, 1'b0);

      // Partial word: keys 5,6,7
      send(5, 1'b0);
      send(6, 1'b0);
      send(7, 1'b1);
      chk("ready_low_pad", o_tuple_ready, 1'b0);
      step();
      chk("ready_low_term2", o_tuple_ready, 1'b0);
      step();
      chk("ready_back", o_tuple_ready, 1'b1);
      chk("run_count_2", o_run_count, 16'd2);
      pop_word("pad_word", seq(5, 3));
      pop_word("pad_term", '0);
      chk("pad_empty", o_empty, 1'b1);

      // Run ending at 9 then run starting at 1: no order error
      send(9, 1'b1);
      send(1, 1'b1);
      step();
      step();
      chk("new_run_no_order", o_err_order, 1'b0);
      pop_word("r9_word", seq(9, 1));
      pop_word("r9_term", '0);
      pop_word("r1_word", seq(1, 1));
      pop_word("r1_term", '0);

      // Descending keys and a zero tuple
      send(3, 1'b0);
      send(2, 1'b1);
      chk("err_order_set", o_err_order, 1'b1);
      chk("err_zero_clear", o_err_zero, 1'b0);
      send(0, 1'b1);
      chk("err_zero_set", o_err_zero, 1'b1);
      step();
      step();
      chk("run_count_6", o_run_count, 16'd6);
      w = seq(3, 1);
      w[DW +: DW] = DW'(2);
      pop_word("desc_word", w);
      pop_word("desc_term", '0);
      pop_word("zero_word", seq(0, 1));
      pop_word("zero_term", '0);

      // Reset mid-run
      for (int unsigned k = 20; k < 25; k++) begin
         send(k, 1'b0);
      end
      i_rst = 1'b1;
      step();
      i_rst = 1'b0;
      #1;
      chk("mid_rst_empty", o_empty, 1'b1);
      chk("mid_rst_run_count", o_run_count, 16'd0);
      chk("mid_rst_err_zero", o_err_zero, 1'b0);
      chk("mid_rst_err_order", o_err_order, 1'b0);
      chk("mid_rst_ready", o_tuple_ready, 1'b1);
      for (int unsigned k = 30; k < 38; k++) begin
         send(k, 1'b0);
      end
      pop_word("post_rst_word", seq(30, 8));

      // Backpressure: continuous valid, no reads
      i_tuple       = DW'(100);
      i_tuple_valid = 1'b1;
      acc = 0;
      for (int c = 0; c < 140; c++) begin
         r = o_tuple_ready;
         step();
         if (r) begin
            acc++;
            i_tuple = i_tuple + DW'(1);
         end
      end
      chk("bp_accepted", 256'(acc), 256'd128);
      chk("bp_ready_low", o_tuple_ready, 1'b0);
      chk("bp_head", o_data, seq(100, 8));
      i_read = 1'b1;
      step();
      i_read = 1'b0;
      chk("bp_ready_after_pop", o_tuple_ready, 1'b1);
      acc = 0;
      for (int c = 0; c < 20; c++) begin
         r = o_tuple_ready;
         step();
         if (r) begin
            acc++;
            i_tuple = i_tuple + DW'(1);
         end
      end
      i_tuple_valid = 1'b0;
      chk("bp_more_accepted", 256'(acc), 256'd8);
      chk("bp_full_again", o_tuple_ready, 1'b0);

      // Simultaneous push and pop at count 15
      pop_word("bp_head2", seq(108, 8));
      chk("ready_at_15", o_tuple_ready, 1'b1);
      for (int unsigned k = 236; k < 243; k++) begin
         send(k, 1'b0);
      end
      chk("sim_head_before", o_data, seq(116, 8));
      chk("sim_ready_before", o_tuple_ready, 1'b1);
      i_tuple       = DW'(243);
      i_tuple_valid = 1'b1;
      i_read        = 1'b1;
      step();
      i_tuple_valid = 1'b0;
      i_read        = 1'b0;
      chk("sim_ready_after", o_tuple_ready, 1'b1);
      for (int unsigned i = 0; i < 15; i++) begin
         pop_word($sformatf("drain_%0d", i), seq(124 + 8 * i, 8));
      end
      chk("drain_empty", o_empty, 1'b1);
      chk("drain_run_count", o_run_count, 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
